// File: rtl/imm_pkg.sv
// Shared encodings for the immediate controller slice.
// Class, FSM state and extender-select constants.
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_ZERO    = 2'b00,
    IMM_12      = 2'b01,
    IMM_16      = 2'b10,
    IMM_CONST32 = 2'b11
  } imm_class_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HI_WAIT = 2'b01,
    OUT     = 2'b10
  } imm_state_e;

  localparam logic SE_12 = 1'b0;
  localparam logic SE_16 = 1'b1;

endpackage

// File: rtl/imm_timer.sv
// Beat-less cycle counter for the CONST32 second half.
// TIMEOUT==0 never expires.
module imm_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (TIMEOUT != 0)) begin
      count_d = count_q + CW'(1);
    end
  end

  // fires on the edge that ends the TIMEOUT-th idle cycle
  assign expire = (TIMEOUT != 0) && inc && !clr &&
                  (count_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/imm_controller.sv
// Immediate extender sequencer with two-beat CONST32 assembly.
// Optional IMM_CTRL_STATS_EN adds a saturating timeout counter.
module imm_controller
  import imm_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_class,
  input  logic [15:0]      in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic [15:0]      se_in,
  output logic             op_se,
  input  logic [31:0]      se_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             err
`ifdef IMM_CTRL_STATS_EN
  ,
  output logic [7:0]       err_count
`endif
);

  imm_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [15:0]      hi_q, hi_d;
  logic             err_q, err_d;
  logic             tmr_clr, tmr_inc, tmr_exp;
  logic             acc;
  imm_class_e       cls;

  assign cls      = imm_class_e'(in_class);
  assign in_ready = (state_q != OUT);
  assign acc      = in_valid && in_ready;
  assign se_in    = in_imm;
  assign op_se    = (cls == IMM_16) ? SE_16 : SE_12;

  imm_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .expire(tmr_exp)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    hi_d        = hi_q;
    err_d       = 1'b0;
    tmr_clr     = 1'b0;
    tmr_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          out_tag_d = in_tag;
          unique case (cls)
            IMM_ZERO: begin
              out_data_d  = '0;
              out_valid_d = 1'b1;
              state_d     = OUT;
            end
            IMM_12, IMM_16: begin
              out_data_d  = se_out;
              out_valid_d = 1'b1;
              state_d     = OUT;
            end
            IMM_CONST32: begin
              hi_d    = in_imm;
              tmr_clr = 1'b1;
              state_d = HI_WAIT;
            end
          endcase
        end
      end
      HI_WAIT: begin
        // a beat beats the timer in the same cycle
        if (acc) begin
          out_data_d  = {hi_q, in_imm};
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          tmr_inc = 1'b1;
          if (tmr_exp) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      hi_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      hi_q        <= hi_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign err       = err_q;

`ifdef IMM_CTRL_STATS_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_controller.sv
// Directed self-checking bench for imm_controller.
// Includes a behavioural signal extender on se_in/op_se/se_out.
module tb_imm_controller;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_class;
  logic [15:0] in_imm;
  logic [4:0]  in_tag;
  logic [15:0] se_in;
  logic        op_se;
  logic [31:0] se_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        err;
`ifdef IMM_CTRL_STATS_EN
  logic [7:0]  err_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  imm_controller #(
    .TAG_W  (5),
    .TIMEOUT(8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_class (in_class),
    .in_imm   (in_imm),
    .in_tag   (in_tag),
    .se_in    (se_in),
    .op_se    (op_se),
    .se_out   (se_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .err      (err)
`ifdef IMM_CTRL_STATS_EN
    ,
    .err_count(err_count)
`endif
  );

  assign se_out = op_se ? {{16{se_in[15]}}, se_in}
                        : {{20{se_in[11]}}, se_in[11:0]};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0]  cls,
                      input logic [15:0] imm,
                      input logic [4:0]  tag,
                      input logic        exp_op);
    in_valid = 1'b1;
    in_class = cls;
    in_imm   = imm;
    in_tag   = tag;
    #1;
    check("op_se", op_se, exp_op);
    check("se_in", se_in, imm);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_ready", in_ready, 1);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_class  = 2'b00;
    in_imm    = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_err", err, 0);
    check("rst_data", out_data, 0);
    check("rst_tag", out_tag, 0);

    // IMM12 sign extension
    send(2'b01, 16'h0800, 5'd1, 1'b0);
    check("i12_valid", out_valid, 1);
    check("i12_data", out_data, 32'hFFFFF800);
    check("i12_tag", out_tag, 5'd1);
    drain();

    // IMM16 negative and positive
    send(2'b10, 16'h8001, 5'd2, 1'b1);
    check("i16n_data", out_data, 32'hFFFF8001);
    drain();
    send(2'b10, 16'h7FFF, 5'd2, 1'b1);
    check("i16p_data", out_data, 32'h00007FFF);
    drain();

    // ZERO ignores the immediate
    send(2'b00, 16'hFFFF, 5'd4, 1'b0);
    check("zero_data", out_data, 0);
    check("zero_tag", out_tag, 5'd4);
    drain();

    // CONST32 with idle gap; low beat class/tag ignored
    send(2'b11, 16'hDEAD, 5'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("c32_wait_valid", out_valid, 0);
      check("c32_wait_ready", in_ready, 1);
      tick();
    end
    send(2'b01, 16'hBEEF, 5'd9, 1'b0);
    check("c32_data", out_data, 32'hDEADBEEF);
    check("c32_tag", out_tag, 5'd3);
    check("c32_err", err, 0);
    check("c32_valid", out_valid, 1);
    drain();

    // timeout after 8 beat-less cycles
    send(2'b11, 16'h1111, 5'd5, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("to_err_early", err, 0);
    end
    tick();
    check("to_err", err, 1);
    check("to_valid", out_valid, 0);
    check("to_ready", in_ready, 1);
`ifdef IMM_CTRL_STATS_EN
    check("to_count", err_count, 8'd1);
`endif
    tick();
    check("to_err_pulse", err, 0);
    check("to_idle_valid", out_valid, 0);

    // beat in the expiring cycle wins
    send(2'b11, 16'hCAFE, 5'd6, 1'b0);
    for (int i = 1; i < 8; i++) tick();
    send(2'b10, 16'hF00D, 5'd7, 1'b1);
    check("race_err", err, 0);
    check("race_data", out_data, 32'hCAFEF00D);
    check("race_tag", out_tag, 5'd6);
    tick();
    check("race_err2", err, 0);
`ifdef IMM_CTRL_STATS_EN
    check("race_count", err_count, 8'd1);
`endif
    drain();

    // backpressure hold; offered request must not be taken
    send(2'b10, 16'h1234, 5'd7, 1'b1);
    in_valid = 1'b1;
    in_class = 2'b00;
    in_imm   = 16'h5555;
    in_tag   = 5'd8;
    for (int i = 0; i < 5; i++) begin
      check("bp_data", out_data, 32'h00001234);
      check("bp_tag", out_tag, 5'd7);
      check("bp_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_drain_valid", out_valid, 0);
    check("bp_drain_ready", in_ready, 1);

    // reset during HI_WAIT
    send(2'b11, 16'hABCD, 5'd1, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rhw_valid", out_valid, 0);
    check("rhw_ready", in_ready, 1);
    check("rhw_err", err, 0);
    for (int i = 0; i < 10; i++) tick();
    check("rhw_no_err", err, 0);
    check("rhw_no_valid", out_valid, 0);

    // reset during OUT
    send(2'b10, 16'h4321, 5'd2, 1'b1);
    check("rout_pre", out_valid, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rout_valid", out_valid, 0);
    check("rout_ready", in_ready, 1);
    check("rout_err", err, 0);
    send(2'b01, 16'h0001, 5'd3, 1'b0);
    check("post_data", out_data, 32'h00000001);
    check("post_tag", out_tag, 5'd3);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_controller.md
Name: imm_controller

Overview:
- Sequences the immediate signal extender: accepts decoded immediate requests, drives the extender's select/input, and registers the 32-bit result toward the register-file write path.
- Adds a two-beat CONST32 mode that assembles a full 32-bit constant from two consecutive 16-bit halves, with a timeout on the second beat.
- Sits between the instruction decoder (upstream, valid/ready) and the operand/writeback mux (downstream, valid/ready).

Parameters:
- TAG_W, 5, width of the destination-register tag carried with each request.
- TIMEOUT, 8, beat-less cycles allowed in HI_WAIT before abort; 0 disables the timeout.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_class  in  2  00 ZERO, 01 IMM12, 10 IMM16, 11 CONST32.
- in_imm  in  16  raw immediate field.
- in_tag  in  TAG_W  destination tag.
- se_in  out  16  to extender input; combinationally equals in_imm.
- op_se  out  1  to extender select; 1 iff in_class==IMM16, else 0.
- se_out  in  32  extender result (combinational return).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  32  result constant.
- out_tag  out  TAG_W  tag of the result.
- err  out  1  one-cycle pulse on CONST32 timeout.

Behaviour:
- Reset (reset==0 at an edge): state←IDLE; out_valid, err, out_data, out_tag, hi register and timer all ←0. Any in-flight operation is discarded, including mid-CONST32 or a pending output.
- States: IDLE, HI_WAIT, OUT.
- in_ready = 1 in IDLE and HI_WAIT; 0 in OUT.
- IDLE, accept:
  - ZERO: out_data←0, state←OUT.
  - IMM12: out_data←se_out (={{20{imm[11]}},imm[11:0]}), state←OUT.
  - IMM16: out_data←se_out (={{16{imm[15]}},imm}), state←OUT.
  - CONST32: hi←in_imm, tag latched, timer←0, state←HI_WAIT.
  - out_tag←in_tag on every accept.
- Latency: accept at edge N → out_valid=1 during cycle N+1.
- HI_WAIT:
  - Any accepted beat is the low half regardless of in_class; its in_tag is ignored.
  - On that beat: out_data←{hi,in_imm}, state←OUT.
  - No beat: timer increments. At the edge ending the TIMEOUT-th consecutive beat-less cycle, state←IDLE, err←1 for exactly one cycle, no output produced.
- OUT:
  - out_valid=1; out_data and out_tag are held stable.
  - out_valid && out_ready → state←IDLE; out_valid←0 next cycle.
- Throughput: at most one result per two cycles; no accept in the same cycle as a drain.
- Simultaneous events: a beat arriving in the cycle the timer would expire wins; no err, result produced.
- err is 0 in every cycle except the timeout pulse.

Optional Feature:
- Macro: IMM_CTRL_STATS_EN.
- Defined: adds output port err_count[7:0], a saturating count (stops at 8'hFF) of timeout events; cleared by reset only.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package imm_pkg:
  - class encodings (IMM_ZERO, IMM_12, IMM_16, IMM_CONST32);
  - FSM state encoding (IDLE, HI_WAIT, OUT);
  - OP_SE select constants (SE_12=0, SE_16=1).
- One natural sub-module: imm_timer, the HI_WAIT beat-less counter with clear/increment/expire and TIMEOUT==0 disable.
- The signal extender stays outside the controller, connected via se_in/op_se/se_out.

Test Plan:
1. IMM12, in_imm=16'h0800 → op_se=0 in accept cycle; out_data=32'hFFFFF800, out_valid=1 at N+1.
2. IMM16, in_imm=16'h8001 then 16'h7FFF → op_se=1; out_data=32'hFFFF8001, then 32'h00007FFF.
3. CONST32 hi=16'hDEAD (tag 5'd3), 3 idle cycles, then low beat 16'hBEEF (tag 5'd9) → out_data=32'hDEADBEEF, out_tag=5'd3, err=0.
4. TIMEOUT=8, CONST32 hi only, 8 beat-less cycles → err high exactly one cycle, state IDLE, no out_valid; with STATS_EN, err_count=1.
5. IMM16 result with out_ready=0 for 5 cycles → out_data/out_tag stable, in_ready=0; out_ready=1 → drain, in_ready=1 next cycle.
6. reset=0 while in HI_WAIT (and separately in OUT) → next cycle out_valid=0, in_ready=1, err=0; a subsequent IMM12 16'h0001 → 32'h00000001.
